// File: rtl/arduino_serial_tx_pkg.sv
// Shared types and constants for the Arduino note-code serial transmitter.
// Holds the FSM state type, the frame header, the default baud divider and
// FIFO depth, the frame payload struct and a helper that assembles it.
package arduino_serial_tx_pkg;

  localparam int unsigned CODE_W         = 3;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned BIT_W          = 3;
  localparam int unsigned DEF_BAUD_DIV   = 5208;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam logic [3:0] FRAME_HEADER = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Transmitted byte; bit 0 (code LSB) goes out first.
  typedef struct packed {
    logic [3:0]        header;
    logic              pad;
    logic [CODE_W-1:0] code;
  } frame_t;

  function automatic frame_t make_frame(input logic [CODE_W-1:0] code);
    frame_t f;
    f.header = FRAME_HEADER;
    f.pad    = 1'b0;
    f.code   = code;
    return f;
  endfunction

endpackage

// File: rtl/arduino_code_fifo.sv
// Small synchronous FIFO buffering 3-bit note codes ahead of the UART.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   push, wr_data  write request and data (ignored when full unless popping)
//   pop            read request (ignored when empty)
//   rd_data_c      head-of-queue data (show-ahead, combinational from storage)
//   full, empty    registered occupancy flags
//   empty_nxt_c    occupancy flag as it will be after this edge
module arduino_code_fifo
  import arduino_serial_tx_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] wr_data,
  output logic [CODE_W-1:0] rd_data_c,
  output logic              full,
  output logic              empty,
  output logic              empty_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [CODE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  count, count_nxt;
  logic              push_ok, pop_ok;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + OCC_W'(1);
      2'b01:   count_nxt = count - OCC_W'(1);
      default: count_nxt = count;
    endcase
  end

  assign empty_nxt_c = (count_nxt == '0);
  assign rd_data_c   = mem[rd_ptr];

  // Pointers and flags; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == OCC_W'(DEPTH));
      empty <= empty_nxt_c;
    end
  end

  // Storage needs no reset: the empty flag guards every read.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/arduino_serial_tx.sv
// Sends each change of the note code to an Arduino as an 8N1 frame carrying
// {1010, 0, code}. Changes are queued in a small FIFO and frames go out
// back-to-back; a change arriving with the queue full is dropped.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   codigo        note code (000 = no note)
//   enable        capture enable for codigo
//   tx            serial line, idle high (registered)
//   ocupado       frame in flight or codes queued (registered)
//   overflow      one-cycle pulse when a code is dropped (registered)
module arduino_serial_tx
  import arduino_serial_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] codigo,
  input  logic              enable,
  output logic              tx,
  output logic              ocupado,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(7);

  tx_state_t         state, state_nxt;
  logic [CODE_W-1:0] ultimo;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_nxt;
  logic [BIT_W-1:0]  bit_idx, bit_idx_nxt;
  frame_t            frame_q, frame_nxt;
  logic              tx_nxt;
  logic              change, pop;
  logic              fifo_full, fifo_empty, fifo_empty_nxt;
  logic [CODE_W-1:0] fifo_data;

  assign change = enable & (codigo != ultimo);

  arduino_code_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (change),
    .pop         (pop),
    .wr_data     (codigo),
    .rd_data_c   (fifo_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt)
  );

  // Next-state and bit timing; tx is computed one edge ahead so it can be registered.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    frame_nxt    = frame_q;
    tx_nxt       = tx;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop          = 1'b1;
          state_nxt    = START;
          baud_cnt_nxt = BAUD_RELOAD;
          frame_nxt    = make_frame(fifo_data);
          tx_nxt       = 1'b0;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          state_nxt    = DATA;
          baud_cnt_nxt = BAUD_RELOAD;
          bit_idx_nxt  = '0;
          tx_nxt       = frame_q[0];
        end else begin
          baud_cnt_nxt = baud_cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_cnt_nxt = BAUD_RELOAD;
          if (bit_idx == LAST_BIT) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + BIT_W'(1);
            tx_nxt      = frame_q[bit_idx_nxt];
          end
        end else begin
          baud_cnt_nxt = baud_cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          // Chain straight into the next start bit when a code is waiting.
          if (!fifo_empty) begin
            pop          = 1'b1;
            state_nxt    = START;
            baud_cnt_nxt = BAUD_RELOAD;
            frame_nxt    = make_frame(fifo_data);
            tx_nxt       = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      frame_q  <= '0;
      ultimo   <= '0;
      tx       <= 1'b1;
      ocupado  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      frame_q  <= frame_nxt;
      tx       <= tx_nxt;
      if (enable) ultimo <= codigo;
      ocupado  <= (state_nxt != IDLE) | ~fifo_empty_nxt;
      overflow <= change & fifo_full & ~pop;
    end
  end

endmodule

// File: tb/tb_arduino_serial_tx.sv
// Directed, self-checking bench for arduino_serial_tx with BAUD_DIV=4.
module tb_arduino_serial_tx;

  localparam int unsigned BAUD      = 4;
  localparam int unsigned DEPTH     = 4;
  localparam int          FRAME_CYC = 10 * BAUD;

  typedef struct {
    logic [2:0] codigo;
    logic       enable;
    logic       tx;
    logic       ocupado;
    logic       overflow;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] codigo;
  logic       enable;
  logic       tx;
  logic       ocupado;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs [44];

  always #5 clock = ~clock;

  arduino_serial_tx #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .codigo   (codigo),
    .enable   (enable),
    .tx       (tx),
    .ocupado  (ocupado),
    .overflow (overflow)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [2:0] c);
    return {4'b1010, 1'b0, c};
  endfunction

  // Expected line level at cycle p (0..39) of a frame carrying code c.
  function automatic logic exp_tx(input logic [2:0] c, input int p);
    int b;
    logic [7:0] by;
    b  = p / BAUD;
    by = exp_byte(c);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[3'(b - 1)];
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    codigo = 3'b000;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_ocupado", ocupado, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    reset = 1'b0;
  endtask

  // Drives stim[e-1] before edge e (last entry held), checks every cycle
  // against frames starting after edge start_e and an overflow pulse after ov_e.
  task automatic run_seq(input string name, input logic [2:0] stim[$], input int ncyc,
                         input logic [2:0] frames[$], input int start_e, input int ov_e);
    int nf;
    int end_e;
    nf    = frames.size();
    end_e = start_e + nf * FRAME_CYC;
    for (int e = 1; e <= ncyc; e++) begin
      logic etx;
      logic eoc;
      codigo = (e - 1 < stim.size()) ? stim[e - 1] : stim[stim.size() - 1];
      enable = 1'b1;
      @(posedge clock);
      #1;
      if (e >= start_e && e < end_e)
        etx = exp_tx(frames[(e - start_e) / FRAME_CYC], (e - start_e) % FRAME_CYC);
      else
        etx = 1'b1;
      eoc = (e < end_e);
      chk({name, "_tx"}, tx, etx);
      chk({name, "_ocupado"}, ocupado, eoc);
      chk({name, "_overflow"}, overflow, (e == ov_e));
    end
  endtask

  initial begin
    logic [7:0] byte_v;
    logic [2:0] stim[$];
    logic [2:0] frames[$];

    // Single frame 000->101: hand-computed waveform table.
    byte_v = 8'b1010_0101;
    for (int k = 0; k < 44; k++) begin
      vecs[k].codigo   = 3'b101;
      vecs[k].enable   = 1'b1;
      vecs[k].overflow = 1'b0;
      vecs[k].ocupado  = (k <= 40);
      if (k == 0)      vecs[k].tx = 1'b1;
      else if (k <= 4) vecs[k].tx = 1'b0;
      else if (k <= 36) vecs[k].tx = byte_v[3'((k - 5) / 4)];
      else             vecs[k].tx = 1'b1;
    end

    do_reset();
    for (int k = 0; k < 44; k++) begin
      codigo = vecs[k].codigo;
      enable = vecs[k].enable;
      @(posedge clock);
      #1;
      chk("single_tx", tx, vecs[k].tx);
      chk("single_ocupado", ocupado, vecs[k].ocupado);
      chk("single_overflow", overflow, vecs[k].overflow);
    end

    // Burst of six changes: five frames back-to-back, 110 dropped.
    do_reset();
    stim.delete(); frames.delete();
    for (int i = 1; i <= 6; i++) stim.push_back(3'(i));
    for (int i = 1; i <= 5; i++) frames.push_back(3'(i));
    run_seq("burst", stim, 212, frames, 2, 6);

    // Full FIFO with a change on the stop-bit end edge: accepted, no overflow.
    do_reset();
    stim.delete(); frames.delete();
    for (int i = 1; i <= 5; i++) stim.push_back(3'(i));
    for (int i = 6; i <= 41; i++) stim.push_back(3'b101);
    stim.push_back(3'b110);
    for (int i = 1; i <= 6; i++) frames.push_back(3'(i));
    run_seq("fullpop", stim, 252, frames, 2, 0);

    // Held code after one change: exactly one frame.
    do_reset();
    stim.delete(); frames.delete();
    stim.push_back(3'b011);
    frames.push_back(3'b011);
    run_seq("repeat", stim, 100, frames, 2, 0);

    // Enable gating: prime ultimo with 010, then toggle with enable low.
    do_reset();
    stim.delete(); frames.delete();
    stim.push_back(3'b010);
    frames.push_back(3'b010);
    run_seq("en_prime", stim, 50, frames, 2, 0);
    for (int i = 0; i < 50; i++) begin
      enable = 1'b0;
      codigo = (i % 2 == 1) ? 3'b001 : 3'b010;
      @(posedge clock);
      #1;
      chk("gated_tx", tx, 1'b1);
      chk("gated_ocupado", ocupado, 1'b0);
    end
    for (int i = 0; i < 50; i++) begin
      enable = 1'b1;
      codigo = 3'b010;
      @(posedge clock);
      #1;
      chk("reenable_tx", tx, 1'b1);
      chk("reenable_ocupado", ocupado, 1'b0);
      chk("reenable_overflow", overflow, 1'b0);
    end

    // Mid-frame reset during data bit 3 with two codes queued.
    do_reset();
    for (int e = 1; e <= 19; e++) begin
      enable = 1'b1;
      codigo = (e == 1) ? 3'b001 : ((e == 2) ? 3'b010 : 3'b011);
      @(posedge clock);
      #1;
    end
    chk("midrst_bit3", tx, 1'b0);
    chk("midrst_busy", ocupado, 1'b1);
    reset  = 1'b1;
    codigo = 3'b000;
    #1;
    chk("midrst_tx_now", tx, 1'b1);
    chk("midrst_ocupado_now", ocupado, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      enable = 1'b1;
      codigo = 3'b000;
      @(posedge clock);
      #1;
      chk("postrst_tx", tx, 1'b1);
      chk("postrst_ocupado", ocupado, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
